// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller.
//
// Owns the program counter and the architectural flag register. It fetches
// a word from instruction RAM, decodes it into fields for the register bank,
// ALU and memory control, and gates each instruction on its condition code.
//
// Optional feature: define SEQ_PERF_CNT_EN to add the Retired_Cnt and
// Annul_Cnt performance counters and their ports.
//
// Ports:
//   Clk, Reset (sync, active-low), Run (start/resume pulse)
//   Instr_Rdata / Instr_Addr / Instr_En   : instruction RAM interface
//   Cond, OpCode, S, Destination, Source_2, Source_1, IV_ShftRor, IV_Mov
//                                         : decoded fields of the latched word
//   New_Flag (ALU flags in), Flag (architectural flags out)
//   Reg_We, Mem_Enable, Mem_RW            : register bank / data memory strobes
//   Busy, Halted                          : status
//   Retired_Cnt, Annul_Cnt                : perf counters (SEQ_PERF_CNT_EN only)
//
// state  | meaning
// IDLE   | out of reset, waiting for Run
// FETCH  | Instr_En high for IMEM_LAT cycles, word latched on the last one
// DECODE | fields on outputs, condition evaluated against Flag
// EXEC   | branch / halt / annul resolved, or dispatch to MEM or WB
// MEM    | Mem_Enable high for DMEM_LAT cycles
// WB     | Reg_We pulse, optional flag update, PC advance
// HALTED | PC held, Run resumes at the instruction after the halt

module cpu_sequencer #(
  parameter int         PC_W     = 8,
  parameter int         DATA_W   = 32,
  parameter int         IMEM_LAT = 1,
  parameter int         DMEM_LAT = 1,
  parameter logic [3:0] LDR_OPC  = 4'b1101,
  parameter logic [3:0] STR_OPC  = 4'b1100,
  parameter logic [3:0] BR_OPC   = 4'b1010,
  parameter logic [3:0] HLT_OPC  = 4'b1111
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] Instr_Rdata,
  output logic [PC_W-1:0]   Instr_Addr,
  output logic              Instr_En,
  output logic [3:0]        Cond,
  output logic [3:0]        OpCode,
  output logic              S,
  output logic [3:0]        Destination,
  output logic [3:0]        Source_2,
  output logic [3:0]        Source_1,
  output logic [4:0]        IV_ShftRor,
  output logic [15:0]       IV_Mov,
  input  logic [3:0]        New_Flag,
  output logic [3:0]        Flag,
  output logic              Reg_We,
  output logic              Mem_Enable,
  output logic              Mem_RW,
  output logic              Busy,
  output logic              Halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       Retired_Cnt,
  output logic [31:0]       Annul_Cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [2:0]      lat_cnt;
  logic            pass;

  // Only the fixed 32-bit field layout is decoded; wider words carry extra
  // bits that are ignored.
  logic unused_rdata;
  assign unused_rdata = ^Instr_Rdata;

  assign Instr_Addr = pc;

  // Flag = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = !cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cy && !z;
      4'b1001: cond_pass = !cy || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      pc          <= '0;
      Flag        <= '0;
      Cond        <= '0;
      OpCode      <= '0;
      S           <= 1'b0;
      Destination <= '0;
      Source_2    <= '0;
      Source_1    <= '0;
      IV_ShftRor  <= '0;
      IV_Mov      <= '0;
      Instr_En    <= 1'b0;
      Reg_We      <= 1'b0;
      Mem_Enable  <= 1'b0;
      Mem_RW      <= 1'b1;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      lat_cnt     <= '0;
      pass        <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
      Retired_Cnt <= '0;
      Annul_Cnt   <= '0;
`endif
    end else begin
      Reg_We <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (Run) begin
            state    <= FETCH;
            Instr_En <= 1'b1;
            Busy     <= 1'b1;
            Halted   <= 1'b0;
            lat_cnt  <= 3'(IMEM_LAT - 1);
          end
        end
        FETCH: begin
          if (lat_cnt == 3'd0) begin
            Cond        <= Instr_Rdata[31:28];
            OpCode      <= Instr_Rdata[27:24];
            S           <= Instr_Rdata[23];
            Destination <= Instr_Rdata[22:19];
            Source_2    <= Instr_Rdata[18:15];
            Source_1    <= Instr_Rdata[14:11];
            IV_ShftRor  <= Instr_Rdata[10:6];
            IV_Mov      <= Instr_Rdata[18:3];
            Instr_En    <= 1'b0;
            state       <= DECODE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        DECODE: begin
          pass  <= cond_pass(Cond, Flag);
          state <= EXEC;
        end
        EXEC: begin
          if (!pass) begin
            pc       <= pc + PC_W'(1);
            state    <= FETCH;
            Instr_En <= 1'b1;
            lat_cnt  <= 3'(IMEM_LAT - 1);
`ifdef SEQ_PERF_CNT_EN
            Annul_Cnt <= Annul_Cnt + 32'd1;
`endif
          end else begin
`ifdef SEQ_PERF_CNT_EN
            Retired_Cnt <= Retired_Cnt + 32'd1;
`endif
            if (OpCode == BR_OPC) begin
              // Sign-extend (or truncate) the 16-bit offset to PC width;
              // the add wraps modulo 2^PC_W like a normal increment.
              pc       <= pc + PC_W'($signed(IV_Mov));
              state    <= FETCH;
              Instr_En <= 1'b1;
              lat_cnt  <= 3'(IMEM_LAT - 1);
            end else if (OpCode == HLT_OPC) begin
              pc     <= pc + PC_W'(1);
              state  <= HALTED;
              Busy   <= 1'b0;
              Halted <= 1'b1;
            end else if (OpCode == LDR_OPC || OpCode == STR_OPC) begin
              state      <= MEM;
              Mem_Enable <= 1'b1;
              Mem_RW     <= (OpCode == LDR_OPC);
              lat_cnt    <= 3'(DMEM_LAT - 1);
            end else begin
              state  <= WB;
              Reg_We <= 1'b1;
            end
          end
        end
        MEM: begin
          if (lat_cnt == 3'd0) begin
            // Mem_Enable drops on the same edge Reg_We rises, so the two
            // strobes never overlap.
            Mem_Enable <= 1'b0;
            Mem_RW     <= 1'b1;
            if (OpCode == LDR_OPC) begin
              state  <= WB;
              Reg_We <= 1'b1;
            end else begin
              pc       <= pc + PC_W'(1);
              state    <= FETCH;
              Instr_En <= 1'b1;
              lat_cnt  <= 3'(IMEM_LAT - 1);
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        WB: begin
          if (S && OpCode != LDR_OPC) Flag <= New_Flag;
          pc       <= pc + PC_W'(1);
          state    <= FETCH;
          Instr_En <= 1'b1;
          lat_cnt  <= 3'(IMEM_LAT - 1);
        end
        default: begin
          state      <= IDLE;
          Instr_En   <= 1'b0;
          Mem_Enable <= 1'b0;
          Busy       <= 1'b0;
          Halted     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. An instruction-level reference
// model runs each program from the condition table and latency rules and
// queues one expected record per instruction; a monitor delimits each
// instruction on the DUT pins and compares it against the queue head.
module tb_cpu_sequencer;
  localparam int PC_W     = 8;
  localparam int DATA_W   = 32;
  localparam int IMEM_LAT = 1;
  localparam int DMEM_LAT = 3;
  localparam int NPROG    = 40;
  localparam logic [3:0] LDR = 4'b1101, STR = 4'b1100, BR = 4'b1010, HLT = 4'b1111;
  localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NE = 4'h1;

  logic              Clk, Reset, Run;
  logic [DATA_W-1:0] Instr_Rdata;
  logic [PC_W-1:0]   Instr_Addr;
  logic              Instr_En;
  logic [3:0]        Cond, OpCode, Destination, Source_2, Source_1;
  logic              S;
  logic [4:0]        IV_ShftRor;
  logic [15:0]       IV_Mov;
  logic [3:0]        New_Flag, Flag;
  logic              Reg_We, Mem_Enable, Mem_RW, Busy, Halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]       Retired_Cnt, Annul_Cnt;
`endif

  logic [31:0] imem   [256];
  logic [3:0]  nf_tab [256];
  assign Instr_Rdata = imem[Instr_Addr];
  assign New_Flag    = nf_tab[Instr_Addr];

  cpu_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .IMEM_LAT(IMEM_LAT), .DMEM_LAT(DMEM_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Instr_Rdata(Instr_Rdata),
    .Instr_Addr(Instr_Addr), .Instr_En(Instr_En), .Cond(Cond), .OpCode(OpCode),
    .S(S), .Destination(Destination), .Source_2(Source_2), .Source_1(Source_1),
    .IV_ShftRor(IV_ShftRor), .IV_Mov(IV_Mov), .New_Flag(New_Flag), .Flag(Flag),
    .Reg_We(Reg_We), .Mem_Enable(Mem_Enable), .Mem_RW(Mem_RW), .Busy(Busy),
    .Halted(Halted)
`ifdef SEQ_PERF_CNT_EN
    , .Retired_Cnt(Retired_Cnt), .Annul_Cnt(Annul_Cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] instr;
    int          cycles;
    int          we;
    int          memc;
    logic        rw;
    logic [3:0]  flag;
    logic [7:0]  pc_after;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;

  int         m_pc, m_ret, m_ann;
  logic [3:0] m_flag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs the program from m_pc up to and including the next taken halt.
  task automatic model_segment(input int fin, output bit done);
    exp_t        e;
    logic [31:0] w;
    int          off;
    done = 1'b1;
    for (int k = 0; k < 600; k++) begin
      w = imem[m_pc];
      e.addr = 8'(m_pc); e.instr = w; e.we = 0; e.memc = 0; e.rw = 1'b1; e.halt = 1'b0;
      if (!cond_ok(w[31:28], m_flag)) begin
        e.cycles = IMEM_LAT + 2;
        m_pc = (m_pc + 1) % 256;
        m_ann++;
      end else begin
        m_ret++;
        case (w[27:24])
          BR: begin
            e.cycles = IMEM_LAT + 2;
            off = int'($signed(w[18:3]));
            m_pc = ((m_pc + off) % 256 + 256) % 256;
          end
          HLT: begin
            e.cycles = IMEM_LAT + 2; e.halt = 1'b1;
            m_pc = (m_pc + 1) % 256;
          end
          LDR: begin
            e.cycles = IMEM_LAT + DMEM_LAT + 3; e.we = 1; e.memc = DMEM_LAT; e.rw = 1'b1;
            m_pc = (m_pc + 1) % 256;
          end
          STR: begin
            e.cycles = IMEM_LAT + DMEM_LAT + 2; e.memc = DMEM_LAT; e.rw = 1'b0;
            m_pc = (m_pc + 1) % 256;
          end
          default: begin
            e.cycles = IMEM_LAT + 3; e.we = 1;
            if (w[23]) m_flag = nf_tab[m_pc];
            m_pc = (m_pc + 1) % 256;
          end
        endcase
      end
      e.flag = m_flag; e.pc_after = 8'(m_pc);
      exp_q.push_back(e);
      if (e.halt) begin
        done = (int'(e.addr) >= fin);
        return;
      end
    end
  endtask

  // Monitor: an instruction starts on a rising Instr_En and ends at the next
  // rising Instr_En or on entry to HALTED.
  initial begin : monitor
    exp_t       e;
    bit         in_instr, prev_en, start, overlap;
    int         cyc, we_n, mem_n;
    logic       rw_and, rw_or;
    logic [7:0] st_addr;
    in_instr = 0; prev_en = 0;
    forever begin
      @(negedge Clk);
      if (!mon_en || !Reset) begin
        in_instr = 0;
      end else begin
        start = Instr_En && !prev_en;
        if (in_instr && (start || Halted)) begin
          in_instr = 0;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_instr: got instruction at %0h expected none", st_addr);
          end else begin
            e = exp_q.pop_front();
            check("instr_addr", st_addr, e.addr);
            check("fields", {Cond, OpCode, S, Destination, Source_2, Source_1, IV_ShftRor}, e.instr[31:6]);
            check("iv_mov", IV_Mov, e.instr[18:3]);
            check("cycles", cyc, e.cycles);
            check("reg_we_count", we_n, e.we);
            check("mem_cycles", mem_n, e.memc);
            if (e.memc > 0) check("mem_rw", {rw_or, rw_and}, {e.rw, e.rw});
            check("we_mem_overlap", overlap, 0);
            check("flag", Flag, e.flag);
            check("pc_after", Instr_Addr, e.pc_after);
            check("halted", Halted, e.halt);
          end
        end
        if (start) begin
          in_instr = 1; st_addr = Instr_Addr; cyc = 0; we_n = 0; mem_n = 0;
          rw_and = 1'b1; rw_or = 1'b0; overlap = 0;
        end
        if (in_instr) begin
          cyc++;
          if (Reg_We) we_n++;
          if (Mem_Enable) begin
            mem_n++; rw_and = rw_and & Mem_RW; rw_or = rw_or | Mem_RW;
          end
          if (Reg_We && Mem_Enable) overlap = 1;
        end
      end
      prev_en = Instr_En;
    end
  end

  task automatic do_reset();
    Reset = 1'b0; Run = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_pc", Instr_Addr, 0);
    check("rst_flag", Flag, 0);
    check("rst_ctrl", {Busy, Halted, Instr_En, Reg_We, Mem_Enable, Mem_RW}, 6'b000001);
    check("rst_fields", {Cond, OpCode, S, Destination, Source_2, Source_1, IV_ShftRor, IV_Mov}, 0);
  endtask

  // Pulses Run, then pokes Run randomly while Busy (must be ignored) until halt.
  task automatic start_and_wait(input int start_pc);
    bit seen;
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    check("run_start", {Instr_En, Instr_Addr}, {1'b1, 8'(start_pc)});
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (Halted) begin seen = 1; break; end
      Run = Busy && ($urandom_range(0, 4) == 0);
    end
    Run = 1'b0;
    check("halt_reached", seen, 1);
  endtask

  task automatic run_program(input int fin);
    int start_pc;
    bit done;
    do_reset();
    m_pc = 0; m_flag = 4'h0; m_ret = 0; m_ann = 0;
    exp_q.delete();
    mon_en = 1;
    for (int seg = 0; seg < 60; seg++) begin
      start_pc = m_pc;
      model_segment(fin, done);
      start_and_wait(start_pc);
      if (done) break;
    end
    @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
`ifdef SEQ_PERF_CNT_EN
    check("retired_cnt", Retired_Cnt, m_ret);
    check("annul_cnt", Annul_Cnt, m_ann);
`endif
    mon_en = 0;
  endtask

  task automatic fill_halts();
    for (int i = 0; i < 256; i++) begin
      imem[i]   = {AL, HLT, 24'h0};
      nf_tab[i] = 4'($urandom);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 99);
    w[31:28] = ($urandom_range(0, 1) == 1) ? AL : 4'($urandom_range(0, 15));
    if (k < 12) begin
      w[27:24] = BR;
      w[18:3]  = 16'($urandom_range(1, 4));
    end else if (k < 20) w[27:24] = HLT;
    else if (k < 35)     w[27:24] = LDR;
    else if (k < 50)     w[27:24] = STR;
    else                 w[27:24] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    Reset = 1'b0; Run = 1'b0;
    fill_halts();

    // Branch wrap, ALU at 0xFF wrapping to 0, flag-setting ALU op then NE annul.
    fill_halts();
    imem[8'h00] = {NE, BR, 1'b0, 4'h0, 16'hFFFE, 3'b000};
    imem[8'hFE] = {AL, BR, 1'b0, 4'h3, 16'hFFFE, 3'b101};
    imem[8'hFC] = {AL, BR, 1'b0, 4'h0, 16'h0003, 3'b000};
    imem[8'hFF] = {AL, 4'h2, 1'b1, 23'h12345};
    nf_tab[8'hFF] = 4'b0100;
    run_program(1);
    check("wrap_final_flag", Flag, 4'b0100);

    // EQ annul with Z clear, halt at 5 then resume at 6, LDR/STR with DMEM_LAT=3.
    fill_halts();
    imem[0] = {EQ, 4'h3, 1'b1, 23'h7};
    for (int i = 1; i <= 4; i++) imem[i] = {AL, 4'(i), 1'b1, 23'($urandom)};
    imem[6] = {AL, LDR, 1'b1, 23'($urandom)};
    imem[7] = {AL, STR, 1'b0, 23'($urandom)};
    run_program(8);

    for (int p = 0; p < 6; p++) begin
      fill_halts();
      for (int i = 0; i < NPROG; i++) imem[i] = rand_instr();
      run_program(NPROG);
    end

    // Reset during MEM, and reset taking priority over Run.
    fill_halts();
    imem[0] = {AL, LDR, 1'b0, 23'h0};
    do_reset();
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (Mem_Enable) begin seen = 1; break; end
    end
    check("mem_phase_reached", seen, 1);
    Reset = 1'b0;
    Run   = 1'b1;
    @(negedge Clk);
    check("rst_mid_mem", {Mem_Enable, Reg_We, Busy, Instr_En, Instr_Addr}, 12'h000);
    Run   = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_after_rst", {Busy, Reg_We, Mem_Enable}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
